cdc_hs_tx: RTL and testbench



---
 rtl/cdc_pkg.sv | 12 +
 rtl/bit_sync.sv | 26 ++
 rtl/cdc_hs_tx.sv | 101 ++++++++++
 tb/tb_cdc_hs_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared types and defaults for the CDC handshake blocks.
package cdc_pkg;

  localparam int CDC_DEF_STAGES = 3;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    REQ_HI      = 2'd1,
    ACK_WAIT_LO = 2'd2
  } hs_tx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop level synchronizer; all stages clear on async reset.
module bit_sync
  import cdc_pkg::*;
#(
  parameter int NO_STAGES = CDC_DEF_STAGES,
  parameter int BUS       = 1
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic [BUS-1:0] i_data,
  output logic [BUS-1:0] o_data
);

  logic [NO_STAGES-1:0][BUS-1:0] sync_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NO_STAGES-2:0], i_data};
    end
  end

  assign o_data = sync_q[NO_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack CDC handshake with optional ack-phase timeout.
//
// state       | meaning
// IDLE        | no transfer in flight; ready when synced ack is low
// REQ_HI      | word held on o_data, o_req high, waiting for ack high
// ACK_WAIT_LO | o_req dropped, o_data still held, waiting for ack low
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int NO_STAGES = CDC_DEF_STAGES,
  parameter int BUS       = 8,
  parameter int TIMEOUT   = 0
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic           i_valid,
  input  logic [BUS-1:0] i_data,
  output logic           o_ready,
  output logic           o_req,
  output logic [BUS-1:0] o_data,
  input  logic           i_async_ack,
  output logic           o_done,
  output logic           o_timeout
);

  hs_tx_state_t state_q;
  hs_tx_state_t state_d;
  logic         ack_s;
  logic         accept;

  bit_sync #(
    .NO_STAGES(NO_STAGES),
    .BUS      (1)
  ) u_ack_sync (
    .i_clk   (i_clk),
    .i_arst_n(i_arst_n),
    .i_data  (i_async_ack),
    .o_data  (ack_s)
  );

  // A stale ack (destination never reset) blocks new requests until it drops.
  assign o_ready = (state_q == IDLE) && !ack_s;
  assign accept  = i_valid && o_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = REQ_HI;
      REQ_HI:      if (ack_s)  state_d = ACK_WAIT_LO;
      ACK_WAIT_LO: if (!ack_s) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      o_req   <= 1'b0;
      o_data  <= '0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_req   <= (state_d == REQ_HI);
      o_done  <= (state_q == ACK_WAIT_LO) && !ack_s;
      if (accept) begin
        o_data <= i_data;
      end
    end
  end

  if (TIMEOUT > 0) begin : g_tmo
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          tmo_q;

    assign cnt_nxt = (cnt_q == TMO_MAX) ? cnt_q : cnt_q + 1'b1;

    // Counter restarts on every phase change; flag is sticky, FSM never aborts.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        cnt_q <= '0;
        tmo_q <= 1'b0;
      end else if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_nxt;
        if (cnt_nxt == TMO_MAX) begin
          tmo_q <= 1'b1;
        end
      end
    end

    assign o_timeout = tmo_q;
  end else begin : g_no_tmo
    assign o_timeout = 1'b0;
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx (NO_STAGES=3, BUS=8, TIMEOUT=10).
module tb_cdc_hs_tx;

  logic       i_clk = 1'b0;
  logic       i_arst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       i_async_ack = 1'b0;
  logic       o_ready;
  logic       o_req;
  logic [7:0] o_data;
  logic       o_done;
  logic       o_timeout;

  int n_vec = 0;
  int n_bad = 0;

  cdc_hs_tx #(
    .NO_STAGES(3),
    .BUS      (8),
    .TIMEOUT  (10)
  ) dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .o_req      (o_req),
    .o_data     (o_data),
    .i_async_ack(i_async_ack),
    .o_done     (o_done),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  int         acc_cnt;
  int         pulse_cnt;
  int         done_cnt;
  int         done_cyc1;
  int         acc_cyc2;
  logic       acc;
  logic       prev_req;
  logic [7:0] seen0;
  logic [7:0] seen1;

  initial begin
    // reset with ack low
    tick();
    tick();
    check("rst_req", o_req, 0);
    check("rst_data", o_data, 0);
    check("rst_done", o_done, 0);
    check("rst_tmo", o_timeout, 0);
    i_arst_n = 1'b1;
    tick();
    check("rst_ready", o_ready, 1);

    // single word A5, ack raised two cycles after accept
    i_valid = 1'b1;
    i_data  = 8'hA5;
    tick();
    check("a5_req_rise", o_req, 1);
    check("a5_data", o_data, 8'hA5);
    check("a5_ready_lo", o_ready, 0);
    i_valid = 1'b0;
    i_data  = 8'hFF;
    tick();
    tick();
    i_async_ack = 1'b1;
    tick();
    tick();
    tick();
    check("a5_req_hold", o_req, 1);
    tick();
    check("a5_req_fall", o_req, 0);
    check("a5_data_hold", o_data, 8'hA5);
    check("a5_done_early", o_done, 0);
    i_async_ack = 1'b0;
    tick();
    tick();
    tick();
    check("a5_done_wait", o_done, 0);
    check("a5_data_wait", o_data, 8'hA5);
    tick();
    check("a5_done", o_done, 1);
    check("a5_ready_back", o_ready, 1);
    tick();
    check("a5_done_once", o_done, 0);
    check("a5_tmo", o_timeout, 0);

    // back-to-back words with responder
    acc_cnt = 0; pulse_cnt = 0; done_cnt = 0;
    done_cyc1 = -1; acc_cyc2 = -2;
    seen0 = 8'h00; seen1 = 8'h00;
    i_valid  = 1'b1;
    i_data   = 8'h01;
    prev_req = o_req;
    for (int cyc = 0; cyc < 80 && done_cnt < 2; cyc++) begin
      acc = i_valid && o_ready;
      tick();
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == 1) i_data = 8'h02;
        else begin
          acc_cyc2 = cyc;
          i_valid  = 1'b0;
        end
      end
      if (o_req && !prev_req) begin
        pulse_cnt++;
        if (pulse_cnt == 1) seen0 = o_data;
        else seen1 = o_data;
      end
      prev_req = o_req;
      if (o_done) begin
        done_cnt++;
        if (done_cnt == 1) done_cyc1 = cyc;
      end
      if (o_req && !i_async_ack) i_async_ack = 1'b1;
      else if (!o_req && i_async_ack) i_async_ack = 1'b0;
    end
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_accepts", acc_cnt, 2);
    check("b2b_req_pulses", pulse_cnt, 2);
    check("b2b_word0", seen0, 8'h01);
    check("b2b_word1", seen1, 8'h02);
    check("b2b_accept_gap", acc_cyc2, done_cyc1 + 1);
    check("b2b_tmo", o_timeout, 0);

    // ack held high across reset release
    i_arst_n    = 1'b0;
    i_async_ack = 1'b1;
    i_valid     = 1'b0;
    tick();
    tick();
    i_arst_n = 1'b1;
    tick();
    tick();
    tick();
    check("stale_ready", o_ready, 0);
    i_valid = 1'b1;
    i_data  = 8'h5A;
    tick();
    tick();
    tick();
    tick();
    check("stale_no_req", o_req, 0);
    check("stale_ready_hold", o_ready, 0);
    i_async_ack = 1'b0;
    tick();
    tick();
    check("stale_ready_2", o_ready, 0);
    tick();
    check("stale_ready_3", o_ready, 1);
    tick();
    check("stale_req", o_req, 1);
    check("stale_data", o_data, 8'h5A);
    i_valid     = 1'b0;
    i_async_ack = 1'b1;
    repeat (4) tick();
    check("stale_req_fall", o_req, 0);
    i_async_ack = 1'b0;
    repeat (4) tick();
    check("stale_done", o_done, 1);

    // timeout with ack withheld
    i_arst_n = 1'b0;
    tick();
    i_arst_n = 1'b1;
    tick();
    i_valid = 1'b1;
    i_data  = 8'h77;
    tick();
    i_valid = 1'b0;
    repeat (9) tick();
    check("tmo_not_yet", o_timeout, 0);
    tick();
    check("tmo_rise", o_timeout, 1);
    check("tmo_req_held", o_req, 1);
    repeat (5) tick();
    check("tmo_sticky", o_timeout, 1);
    i_async_ack = 1'b1;
    repeat (4) tick();
    check("tmo_late_req_fall", o_req, 0);
    i_async_ack = 1'b0;
    repeat (4) tick();
    check("tmo_late_done", o_done, 1);
    check("tmo_after_done", o_timeout, 1);
    #2 i_arst_n = 1'b0;
    #1;
    check("tmo_rst_clear", o_timeout, 0);
    tick();
    i_arst_n = 1'b1;
    tick();

    // async reset during REQ_HI
    i_valid = 1'b1;
    i_data  = 8'h3C;
    tick();
    i_valid = 1'b0;
    check("abort_req", o_req, 1);
    check("abort_data", o_data, 8'h3C);
    tick();
    tick();
    #2 i_arst_n = 1'b0;
    #1;
    check("abort_req_async", o_req, 0);
    check("abort_data_async", o_data, 0);
    #2 i_arst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_ready", o_ready, 1);
    check("abort_req_idle", o_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
